// File: rtl/ram_slot_arbiter_pkg.sv
// Shared constants for the RAM slot arbiter: requester indices, one-hot grant codes
// and the phase windows used by the strobe decode.
package ram_slot_arbiter_pkg;

  localparam int REQ_VID = 0;
  localparam int REQ_SND = 1;
  localparam int REQ_REF = 2;
  localparam int REQ_CPU = 3;
  localparam int REQ_DMA = 4;
  localparam int NUM_REQ = 5;

  localparam logic [2:0] PH_FIRST    = 3'd0;
  localparam logic [2:0] PH_LAST     = 3'd7;
  localparam logic [2:0] OE_FIRST    = 3'd1;
  localparam logic [2:0] OE_LAST     = 3'd6;
  localparam logic [2:0] WE_FIRST    = 3'd2;
  localparam logic [2:0] WE_LAST     = 3'd5;
  localparam logic [2:0] RF_FIRST    = 3'd1;
  localparam logic [2:0] RF_LAST     = 3'd6;
  localparam logic [2:0] DTACK_FIRST = 3'd4;

  typedef enum logic [NUM_REQ-1:0] {
    GNT_IDLE = 5'b00000,
    GNT_VID  = 5'b00001,
    GNT_SND  = 5'b00010,
    GNT_REF  = 5'b00100,
    GNT_CPU  = 5'b01000,
    GNT_DMA  = 5'b10000
  } grant_e;

  function automatic logic in_window(input logic [2:0] ph, input logic [2:0] lo,
                                     input logic [2:0] hi);
    return (ph >= lo) && (ph <= hi);
  endfunction

endpackage

// File: rtl/ram_slot_arbiter_refresh.sv
// Refresh bookkeeping: counts slots between refresh requests, ages a pending request
// until it becomes urgent, and flags an interval that expires with a request still pending.
module ram_refresh_timer
  import ram_slot_arbiter_pkg::*;
#(
  parameter int REF_INTERVAL  = 64,
  parameter int REF_MAX_DEFER = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic slot_end_i,
  input  logic ref_done_i,
  output logic pending_o,
  output logic urgent_o,
  output logic overrun_o
);

  localparam int CNT_W = $clog2(REF_INTERVAL);
  localparam int AGE_W = $clog2(REF_MAX_DEFER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_INTERVAL - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(REF_MAX_DEFER);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic             tick_s;

  always_comb begin
    tick_s    = slot_end_i && (cnt_q == CNT_LAST);
    cnt_d     = cnt_q;
    age_d     = age_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (slot_end_i) begin
      cnt_d = tick_s ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
      // A tick landing on the service slot re-arms immediately with a fresh age.
      if (ref_done_i) begin
        pending_d = tick_s;
        age_d     = {AGE_W{1'b0}};
      end else if (tick_s && !pending_q) begin
        pending_d = 1'b1;
        age_d     = {AGE_W{1'b0}};
      end else if (pending_q) begin
        overrun_d = overrun_q | tick_s;
        age_d     = (age_q != AGE_MAX) ? age_q + AGE_W'(1) : age_q;
      end else begin
        pending_d = pending_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q     <= {CNT_W{1'b0}};
      age_q     <= {AGE_W{1'b0}};
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      age_q     <= age_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending_o = pending_q;
  assign urgent_o  = pending_q && (age_q >= AGE_MAX);
  assign overrun_o = overrun_q;

endmodule

// File: rtl/ram_slot_arbiter.sv
// Eight-phase RAM slot sequencer: alternates video and CPU slots, picks one owner per
// slot, lets the CPU claim an idle slot early in the slot, and decodes the RAM strobes.
module ram_slot_arbiter
  import ram_slot_arbiter_pkg::*;
#(
  parameter int REF_INTERVAL  = 64,
  parameter int REF_MAX_DEFER = 8,
  parameter int CPU_BORROW    = 1,
  parameter int LATE_CLAIM_PH = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clk_en_i,
  input  logic       vid_req_i,
  input  logic       snd_req_i,
  input  logic       cpu_req_i,
  input  logic       cpu_we_i,
  input  logic       dma_req_i,
  input  logic       dma_we_i,
  output logic [2:0] bus_phase_o,
  output logic       video_slot_o,
  output logic [4:0] grant_o,
  output logic [4:0] ack_o,
  output logic       cpu_dtack_o,
  output logic       ram_oe_o,
  output logic       ram_we_o,
  output logic       ram_refresh_o,
  output logic       ref_overrun_o
);

  localparam logic [2:0] LATE_PH = 3'(LATE_CLAIM_PH);

  logic [2:0] phase_q, phase_d;
  logic       video_q, video_d;
  grant_e     grant_q, grant_d;
  logic       wr_q, wr_d;
  logic       cpu_abort_q, cpu_abort_d;
  logic       oe_q, oe_d, we_q, we_d, rf_q, rf_d, dtack_q, dtack_d;

  grant_e     sel_s;
  logic       sel_wr_s;
  logic       slot_end_s, decide_s, late_ok_s, rw_s;
  logic       ref_pending_s, ref_urgent_s, ref_overrun_s;

  ram_refresh_timer #(
    .REF_INTERVAL (REF_INTERVAL),
    .REF_MAX_DEFER(REF_MAX_DEFER)
  ) u_refresh (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .slot_end_i(slot_end_s),
    .ref_done_i(slot_end_s && (grant_q == GNT_REF)),
    .pending_o (ref_pending_s),
    .urgent_o  (ref_urgent_s),
    .overrun_o (ref_overrun_s)
  );

  // Slot owner candidate for the decision taken at phase 0.
  always_comb begin
    sel_s    = GNT_IDLE;
    sel_wr_s = 1'b0;
    if (video_q) begin
      if (vid_req_i) begin
        sel_s = GNT_VID;
      end else if (snd_req_i) begin
        sel_s = GNT_SND;
      end else if (ref_pending_s) begin
        sel_s = GNT_REF;
      end else if ((CPU_BORROW != 0) && cpu_req_i) begin
        sel_s    = GNT_CPU;
        sel_wr_s = cpu_we_i;
      end else begin
        sel_s = GNT_IDLE;
      end
    end else begin
      if (ref_urgent_s) begin
        sel_s = GNT_REF;
      end else if (cpu_req_i) begin
        sel_s    = GNT_CPU;
        sel_wr_s = cpu_we_i;
      end else if (dma_req_i) begin
        sel_s    = GNT_DMA;
        sel_wr_s = dma_we_i;
      end else begin
        sel_s = GNT_IDLE;
      end
    end
  end

  // Next phase, slot type, grant and registered strobe values.
  always_comb begin
    slot_end_s = clk_en_i && (phase_q == PH_LAST);
    decide_s   = clk_en_i && (phase_q == PH_FIRST);
    late_ok_s  = clk_en_i && (grant_q == GNT_IDLE) && (phase_q >= 3'd1) &&
                 (phase_q <= LATE_PH) && cpu_req_i && (!video_q || (CPU_BORROW != 0));
    phase_d    = clk_en_i ? phase_q + 3'd1 : phase_q;
    video_d    = slot_end_s ? !video_q : video_q;
    grant_d    = grant_q;
    wr_d       = wr_q;
    if (slot_end_s) begin
      grant_d = GNT_IDLE;
      wr_d    = 1'b0;
    end else if (decide_s) begin
      grant_d = sel_s;
      wr_d    = sel_wr_s;
    end else if (late_ok_s) begin
      grant_d = GNT_CPU;
      wr_d    = cpu_we_i;
    end else begin
      grant_d = grant_q;
    end

    // A CPU that lets go of its request forfeits the ack but not the strobes.
    cpu_abort_d = cpu_abort_q;
    if (decide_s) begin
      cpu_abort_d = 1'b0;
    end else if (clk_en_i && (grant_q == GNT_CPU) && !cpu_req_i) begin
      cpu_abort_d = 1'b1;
    end else begin
      cpu_abort_d = cpu_abort_q;
    end

    rw_s    = (grant_d == GNT_CPU) || (grant_d == GNT_DMA);
    oe_d    = in_window(phase_d, OE_FIRST, OE_LAST) &&
              ((grant_d == GNT_VID) || (grant_d == GNT_SND) || (rw_s && !wr_d));
    we_d    = in_window(phase_d, WE_FIRST, WE_LAST) && rw_s && wr_d;
    rf_d    = in_window(phase_d, RF_FIRST, RF_LAST) && (grant_d == GNT_REF);
    dtack_d = (grant_d == GNT_CPU) && (phase_d >= DTACK_FIRST) && cpu_req_i;
  end

  // State and output registers; everything holds while clk_en is low.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      phase_q     <= 3'd0;
      video_q     <= 1'b1;
      grant_q     <= GNT_IDLE;
      wr_q        <= 1'b0;
      cpu_abort_q <= 1'b0;
      oe_q        <= 1'b0;
      we_q        <= 1'b0;
      rf_q        <= 1'b0;
      dtack_q     <= 1'b0;
    end else if (clk_en_i) begin
      phase_q     <= phase_d;
      video_q     <= video_d;
      grant_q     <= grant_d;
      wr_q        <= wr_d;
      cpu_abort_q <= cpu_abort_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      rf_q        <= rf_d;
      dtack_q     <= dtack_d;
    end
  end

  // Ack is a single-clock pulse on the enabled phase-7 cycle of the owning slot.
  always_comb begin
    if (slot_end_s && !((grant_q == GNT_CPU) && (cpu_abort_q || !cpu_req_i))) begin
      ack_o = grant_q;
    end else begin
      ack_o = 5'b00000;
    end
  end

  assign bus_phase_o   = phase_q;
  assign video_slot_o  = video_q;
  assign grant_o       = grant_q;
  assign cpu_dtack_o   = dtack_q;
  assign ram_oe_o      = oe_q;
  assign ram_we_o      = we_q;
  assign ram_refresh_o = rf_q;
  assign ref_overrun_o = ref_overrun_s;

endmodule

// File: tb/tb_ram_slot_arbiter.sv
// Self-checking bench for ram_slot_arbiter: a slot-level reference model checked every
// cycle, a table-driven late-claim sequence, and directed multi-cycle corner cases.
module tb_ram_slot_arbiter;
  import ram_slot_arbiter_pkg::*;

  localparam int RI = 64;
  localparam int RD = 8;
  localparam int LC = 2;

  logic clk, rst, clk_en, vid, snd, cpu, cpu_we, dma, dma_we;
  logic [2:0] bus_phase;
  logic       video_slot, cpu_dtack, ram_oe, ram_we, ram_refresh, ref_overrun;
  logic [4:0] grant, ack;
  logic [2:0] s_phase;
  logic       s_vs, s_dt, s_oe, s_we, s_rf, s_ovr;
  logic [4:0] s_grant, s_ack;

  ram_slot_arbiter dut (
    .clk_i(clk), .reset_i(rst), .clk_en_i(clk_en), .vid_req_i(vid), .snd_req_i(snd),
    .cpu_req_i(cpu), .cpu_we_i(cpu_we), .dma_req_i(dma), .dma_we_i(dma_we),
    .bus_phase_o(bus_phase), .video_slot_o(video_slot), .grant_o(grant), .ack_o(ack),
    .cpu_dtack_o(cpu_dtack), .ram_oe_o(ram_oe), .ram_we_o(ram_we),
    .ram_refresh_o(ram_refresh), .ref_overrun_o(ref_overrun)
  );

  ram_slot_arbiter #(.REF_INTERVAL(4), .REF_MAX_DEFER(8)) u_small (
    .clk_i(clk), .reset_i(rst), .clk_en_i(clk_en), .vid_req_i(vid), .snd_req_i(snd),
    .cpu_req_i(cpu), .cpu_we_i(cpu_we), .dma_req_i(dma), .dma_we_i(dma_we),
    .bus_phase_o(s_phase), .video_slot_o(s_vs), .grant_o(s_grant), .ack_o(s_ack),
    .cpu_dtack_o(s_dt), .ram_oe_o(s_oe), .ram_we_o(s_we),
    .ram_refresh_o(s_rf), .ref_overrun_o(s_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: slot index since reset, phase within slot, owner index (-1 idle).
  int m_phase, m_slot, m_owner, m_age;
  bit m_pend, m_ovr, m_wr, m_abort, e_oe, e_we, e_rf, e_dt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_slot = 0; m_owner = -1; m_age = 0;
    m_pend = 0; m_ovr = 0; m_wr = 0; m_abort = 0;
    e_oe = 0; e_we = 0; e_rf = 0; e_dt = 0;
  endtask

  task automatic model_clock();
    bit vs, done, tick;
    if (rst || !clk_en) return;
    vs = (m_slot % 2 == 0);
    if (m_phase == 0) m_abort = 0;
    else if (m_owner == REQ_CPU && !cpu) m_abort = 1;
    if (m_phase == 7) begin
      done = (m_owner == REQ_REF);
      tick = ((m_slot + 1) % RI == 0);
      if (done) begin m_pend = tick; m_age = 0; end
      else if (tick && !m_pend) begin m_pend = 1; m_age = 0; end
      else if (m_pend) begin
        if (tick) m_ovr = 1;
        if (m_age < RD) m_age++;
      end
      m_owner = -1; m_wr = 0;
    end else if (m_phase == 0) begin
      m_owner = -1; m_wr = 0;
      if (vs) begin
        if (vid) m_owner = REQ_VID;
        else if (snd) m_owner = REQ_SND;
        else if (m_pend) m_owner = REQ_REF;
        else if (cpu) begin m_owner = REQ_CPU; m_wr = cpu_we; end
      end else begin
        if (m_pend && m_age >= RD) m_owner = REQ_REF;
        else if (cpu) begin m_owner = REQ_CPU; m_wr = cpu_we; end
        else if (dma) begin m_owner = REQ_DMA; m_wr = dma_we; end
      end
    end else if (m_phase <= LC && m_owner < 0 && cpu) begin
      m_owner = REQ_CPU; m_wr = cpu_we;
    end
    m_phase = (m_phase + 1) % 8;
    if (m_phase == 0) m_slot++;
    e_oe = (m_phase >= 1 && m_phase <= 6) && (m_owner == REQ_VID || m_owner == REQ_SND ||
           ((m_owner == REQ_CPU || m_owner == REQ_DMA) && !m_wr));
    e_we = (m_phase >= 2 && m_phase <= 5) && (m_owner == REQ_CPU || m_owner == REQ_DMA) && m_wr;
    e_rf = (m_phase >= 1 && m_phase <= 6) && (m_owner == REQ_REF);
    e_dt = (m_owner == REQ_CPU) && (m_phase >= 4) && cpu;
  endtask

  task automatic check_model();
    logic [4:0] eg, ea;
    eg = (m_owner < 0) ? 5'd0 : 5'(1 << m_owner);
    ea = (clk_en && m_phase == 7 && m_owner >= 0 &&
          !(m_owner == REQ_CPU && (m_abort || !cpu))) ? eg : 5'd0;
    chk("phase", bus_phase, m_phase);
    chk("video_slot", video_slot, (m_slot % 2 == 0));
    chk("grant", grant, eg);
    chk("ack", ack, ea);
    chk("dtack", cpu_dtack, e_dt);
    chk("ram_oe", ram_oe, e_oe);
    chk("ram_we", ram_we, e_we);
    chk("ram_refresh", ram_refresh, e_rf);
    chk("ref_overrun", ref_overrun, m_ovr);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    bit         en;
    bit         c;
    logic [2:0] ph;
    bit         vs;
    logic [4:0] gnt;
    logic [4:0] ak;
    bit         dt;
    bit         oe;
  } vec_t;
  vec_t tbl[13];

  int first_slot, rf_cnt, ack_cnt;

  initial begin
    // Late claim in a video slot at phase 2, then a too-late request at phase 3.
    tbl[0]  = '{1'b1, 1'b0, 3'd1, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 3'd2, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 3'd3, 1'b1, 5'b01000, 5'b00000, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 3'd4, 1'b1, 5'b01000, 5'b00000, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 3'd5, 1'b1, 5'b01000, 5'b00000, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 3'd6, 1'b1, 5'b01000, 5'b00000, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 3'd7, 1'b1, 5'b01000, 5'b01000, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 3'd0, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 3'd1, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 3'd2, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 3'd3, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 3'd4, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 3'd5, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0};

    rst = 1'b1; clk_en = 1'b0; vid = 1'b0; snd = 1'b0; cpu = 1'b0; cpu_we = 1'b0;
    dma = 1'b0; dma_we = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_phase", bus_phase, 3'd0);
    chk("reset_video_slot", video_slot, 1'b1);
    chk("reset_grant", grant, 5'd0);
    chk("reset_strobes", {ram_oe, ram_we, ram_refresh, cpu_dtack, ref_overrun}, 5'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      clk_en = tbl[i].en; cpu = tbl[i].c;
      cyc();
      chk($sformatf("tbl%0d_phase", i), bus_phase, tbl[i].ph);
      chk($sformatf("tbl%0d_vs", i), video_slot, tbl[i].vs);
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].gnt);
      chk($sformatf("tbl%0d_ack", i), ack, tbl[i].ak);
      chk($sformatf("tbl%0d_dtack", i), cpu_dtack, tbl[i].dt);
      chk($sformatf("tbl%0d_oe", i), ram_oe, tbl[i].oe);
    end

    // Idle bus: the first owner is refresh, in video slot 64.
    cpu = 1'b0; clk_en = 1'b1;
    do_reset();
    for (int i = 0; i < 8 * 70 && grant == 5'd0; i++) cyc();
    chk("idle_first_grant_slot", m_slot, 64);
    chk("idle_first_grant", grant, 5'b00100);

    // Video plus CPU: alternating owners; the short-interval instance overruns.
    vid = 1'b1; cpu = 1'b1;
    do_reset();
    for (int i = 0; i < 8 * 10; i++) begin
      cyc();
      if (m_slot == 7 && m_phase == 3) chk("small_overrun_before", s_ovr, 1'b0);
      if (m_slot == 8 && m_phase == 1) chk("small_overrun_after", s_ovr, 1'b1);
    end

    // Saturated bus: refresh becomes urgent and takes CPU slot 73.
    snd = 1'b1;
    do_reset();
    first_slot = -1; rf_cnt = 0;
    for (int i = 0; i < 8 * 80; i++) begin
      cyc();
      if (first_slot < 0 && grant == 5'b00100) first_slot = m_slot;
      if (first_slot >= 0 && m_slot == first_slot && ram_refresh) rf_cnt++;
    end
    chk("urgent_ref_slot", first_slot, 73);
    chk("urgent_ref_strobe_clks", rf_cnt, 6);
    chk("urgent_no_overrun", ref_overrun, 1'b0);

    // Sparse clock enable with CPU writes: one ack clock per slot.
    vid = 1'b0; snd = 1'b0; cpu_we = 1'b1;
    ack_cnt = 0;
    for (int i = 0; i < 128; i++) begin
      clk_en = (i % 4 == 0);
      cyc();
      if (ack != 5'd0) ack_cnt++;
    end
    chk("sparse_ack_clks", ack_cnt, 4);
    clk_en = 1'b1;

    // Reset in the middle of a DMA write drops the strobe immediately.
    cpu = 1'b0; cpu_we = 1'b0; dma = 1'b1; dma_we = 1'b1;
    do_reset();
    for (int i = 0; i < 40 && !(grant == 5'b10000 && bus_phase == 3'd5); i++) cyc();
    chk("dma_reach_phase5", {grant, bus_phase}, {5'b10000, 3'd5});
    chk("dma_we_before_reset", ram_we, 1'b1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("abort_ram_we", ram_we, 1'b0);
    chk("abort_grant", grant, 5'd0);
    chk("abort_phase", bus_phase, 3'd0);
    chk("abort_video_slot", video_slot, 1'b1);
    cyc();
    rst = 1'b0;
    dma = 1'b0; dma_we = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      clk_en = ($urandom_range(0, 3) != 0);
      vid    = ($urandom_range(0, 2) == 0);
      snd    = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) cpu = !cpu;
      cpu_we = ($urandom_range(0, 1) == 1);
      dma    = ($urandom_range(0, 1) == 1);
      dma_we = ($urandom_range(0, 1) == 1);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
